// File: rtl/estado_fsm.sv
// estado_fsm: supervisory OFF -> START -> RUN sequencer feeding the 7-segment
// display controller. Power switch, fault sensors and acknowledge button are
// synchronized (2 flops) and optionally debounced before use.
// Build option: define ESTADO_DEBOUNCE_EN to include the debouncers; when it is
// undefined the debounced value is the synchronizer output and DEB is unused.
// estado : [5] off, [4] alarm latched, [3:1] live faults, [0] normal.
// nfallas: saturating count of alarm-latch set events.
module estado_fsm #(
   parameter int unsigned DEB   = 16,
   parameter int unsigned T_ARR = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enc,
   input  logic [2:0] sens,
   input  logic       ack,
   output logic [5:0] estado,
   output logic [7:0] nfallas
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam logic [15:0] T_ARR_LAST = 16'(T_ARR - 1);

   // Bit packing of all raw inputs: [0] enc, [3:1] sens, [4] ack.
   logic [4:0] raw_s;
   logic [4:0] sync1_r;
   logic [4:0] sync2_r;
   logic [4:0] deb_s;

   logic       on_s;
   logic [2:0] f_s;
   logic       ack_pulse_s;
   logic       ack_prev_r;

   state_t     state_r;
   state_t     state_n_s;
   logic [15:0] start_cnt_r;
   logic [15:0] start_cnt_n_s;
   logic       alm_r;
   logic       alm_n_s;
   logic       alm_prev_r;
   logic [5:0] estado_r;
   logic [5:0] estado_n_s;
   logic [7:0] nfallas_r;

   assign raw_s = {ack, sens, enc};

   // Two-flop synchronizer for every raw input bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= 5'd0;
         sync2_r <= 5'd0;
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
      end
   end

`ifdef ESTADO_DEBOUNCE_EN
   localparam logic [16:0] DEB_LIM = 17'(DEB);

   logic [15:0] deb_cnt_r [0:4];
   logic [4:0]  deb_r;

   // Per-bit debouncer: accept a new level only after DEB consecutive differing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb_r <= 5'd0;
         for (int i = 0; i < 5; i++) begin
            deb_cnt_r[i] <= 16'd0;
         end
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (sync2_r[i] == deb_r[i]) begin
               deb_cnt_r[i] <= 16'd0;
            end else if (({1'b0, deb_cnt_r[i]} + 17'd1) == DEB_LIM) begin
               deb_r[i]     <= sync2_r[i];
               deb_cnt_r[i] <= 16'd0;
            end else begin
               deb_cnt_r[i] <= deb_cnt_r[i] + 16'd1;
            end
         end
      end
   end

   assign deb_s = deb_r;
`else
   assign deb_s = sync2_r;
`endif

   assign on_s        = deb_s[0];
   assign f_s         = deb_s[3:1];
   assign ack_pulse_s = deb_s[4] & ~ack_prev_r;

   // Next state, START timer, alarm latch and display code; estado is derived
   // from the post-edge state and alarm so it is glitch-free and aligned.
   always_comb begin
      state_n_s     = state_r;
      start_cnt_n_s = start_cnt_r;
      alm_n_s       = alm_r;
      estado_n_s    = 6'b100000;

      case (state_r)
         ST_OFF: begin
            start_cnt_n_s = 16'd0;
            if (on_s) begin
               state_n_s = ST_START;
            end else begin
               state_n_s = ST_OFF;
            end
         end
         ST_START: begin
            if (!on_s) begin
               state_n_s     = ST_OFF;
               start_cnt_n_s = 16'd0;
            end else if (start_cnt_r == T_ARR_LAST) begin
               state_n_s     = ST_RUN;
               start_cnt_n_s = 16'd0;
            end else begin
               state_n_s     = ST_START;
               start_cnt_n_s = start_cnt_r + 16'd1;
            end
         end
         ST_RUN: begin
            start_cnt_n_s = 16'd0;
            if (!on_s) begin
               state_n_s = ST_OFF;
            end else begin
               state_n_s = ST_RUN;
            end
         end
         default: begin
            state_n_s     = ST_OFF;
            start_cnt_n_s = 16'd0;
         end
      endcase

      // A present fault always wins over an acknowledge in the same cycle.
      if (state_n_s == ST_RUN) begin
         if (|f_s) begin
            alm_n_s = 1'b1;
         end else if (ack_pulse_s) begin
            alm_n_s = 1'b0;
         end else begin
            alm_n_s = alm_r;
         end
      end else begin
         alm_n_s = 1'b0;
      end

      case (state_n_s)
         ST_OFF:   estado_n_s = 6'b100000;
         ST_START: estado_n_s = 6'b000000;
         ST_RUN:   estado_n_s = {1'b0, alm_n_s, f_s, (~alm_n_s) & (~|f_s)};
         default:  estado_n_s = 6'b100000;
      endcase
   end

   // State, timer, alarm and display registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_OFF;
         start_cnt_r <= 16'd0;
         alm_r       <= 1'b0;
         alm_prev_r  <= 1'b0;
         ack_prev_r  <= 1'b0;
         estado_r    <= 6'b100000;
      end else begin
         state_r     <= state_n_s;
         start_cnt_r <= start_cnt_n_s;
         alm_r       <= alm_n_s;
         alm_prev_r  <= alm_r;
         ack_prev_r  <= deb_s[4];
         estado_r    <= estado_n_s;
      end
   end

   // Alarm event counter: one count per latch rising edge, saturating at 255.
   always_ff @(posedge clk) begin
      if (reset) begin
         nfallas_r <= 8'd0;
      end else if (alm_r && !alm_prev_r && (nfallas_r != 8'd255)) begin
         nfallas_r <= nfallas_r + 8'd1;
      end else begin
         nfallas_r <= nfallas_r;
      end
   end

   assign estado  = estado_r;
   assign nfallas = nfallas_r;

endmodule

// File: tb/tb_estado_fsm.sv
// Self-checking bench for estado_fsm: directed scenarios with literal
// expectations plus randomized stimulus, all compared every cycle against a
// behavioural model. Works with or without ESTADO_DEBOUNCE_EN.
module tb_estado_fsm;

   localparam int DEB   = 4;
   localparam int T_ARR = 8;
`ifdef ESTADO_DEBOUNCE_EN
   localparam int LAT = DEB + 3;
   localparam int NF_AFTER_GLITCH = 2;
`else
   localparam int LAT = 3;
   localparam int NF_AFTER_GLITCH = 3;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enc = 1'b0;
   logic [2:0] sens = 3'b000;
   logic       ack = 1'b0;
   logic [5:0] estado;
   logic [7:0] nfallas;

   int checks = 0;
   int errors = 0;

   estado_fsm #(.DEB(DEB), .T_ARR(T_ARR)) dut (
      .clk     (clk),
      .reset   (reset),
      .enc     (enc),
      .sens    (sens),
      .ack     (ack),
      .estado  (estado),
      .nfallas (nfallas)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   localparam int M_OFF = 0, M_START = 1, M_RUN = 2;
   bit [4:0]   m_pipe[$];     // raw samples still travelling through the synchronizer
   bit [4:0]   m_d;           // accepted levels
   int         m_streak[5];   // consecutive samples disagreeing with accepted level
   bit         m_ack_seen;
   int         m_mode;
   int         m_left;        // START cycles remaining
   bit         m_alm;
   bit         m_pending;     // latch rose, count on next edge
   int         m_nf;
   logic [5:0] m_est;

   task automatic model_reset();
      m_pipe.delete();
      m_pipe.push_back(5'd0);
      m_pipe.push_back(5'd0);
      m_d = 5'd0;
      for (int i = 0; i < 5; i++) m_streak[i] = 0;
      m_ack_seen = 1'b0;
      m_mode = M_OFF;
      m_left = 0;
      m_alm = 1'b0;
      m_pending = 1'b0;
      m_nf = 0;
      m_est = 6'b100000;
   endtask

   task automatic model_step(input bit rst, input bit [4:0] raw);
      bit       on;
      bit [2:0] f;
      bit       ap;
      bit       was_alm;
      bit [4:0] synced;
      if (rst) begin
         model_reset();
      end else begin
         on = m_d[0];
         f  = m_d[3:1];
         ap = m_d[4] && !m_ack_seen;
         if (m_pending) begin
            m_nf = (m_nf < 255) ? m_nf + 1 : 255;
            m_pending = 1'b0;
         end
         if (!on) begin
            m_mode = M_OFF;
         end else if (m_mode == M_OFF) begin
            m_mode = M_START;
            m_left = T_ARR;
         end else if (m_mode == M_START) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_RUN;
         end
         was_alm = m_alm;
         if (m_mode != M_RUN) m_alm = 1'b0;
         else if (f != 3'b000) m_alm = 1'b1;
         else if (ap) m_alm = 1'b0;
         if (!was_alm && m_alm) m_pending = 1'b1;
         if (m_mode == M_OFF) m_est = 6'b100000;
         else if (m_mode == M_START) m_est = 6'b000000;
         else m_est = {1'b0, m_alm, f, (!m_alm && f == 3'b000)};
         m_ack_seen = m_d[4];
         synced = m_pipe.pop_front();
         m_pipe.push_back(raw);
`ifdef ESTADO_DEBOUNCE_EN
         for (int i = 0; i < 5; i++) begin
            if (synced[i] != m_d[i]) begin
               m_streak[i] = m_streak[i] + 1;
               if (m_streak[i] >= DEB) begin
                  m_d[i] = synced[i];
                  m_streak[i] = 0;
               end
            end else begin
               m_streak[i] = 0;
            end
         end
`else
         m_d = m_pipe[0];
`endif
      end
   endtask

   // One clock: advance the model with the inputs the DUT samples, then compare.
   task automatic tick();
      @(posedge clk);
      model_step(reset, {ack, sens, enc});
      #1;
      checks++;
      if (estado !== m_est) begin
         errors++;
         $display("FAIL estado_model t=%0t got=%b exp=%b", $time, estado, m_est);
      end
      checks++;
      if (nfallas !== 8'(m_nf)) begin
         errors++;
         $display("FAIL nfallas_model t=%0t got=%0d exp=%0d", $time, nfallas, m_nf);
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   initial begin
      model_reset();
      // Reset, then power on and sequence to RUN.
      reset = 1'b1;
      ticks(2);
      chk("reset_estado", {2'b00, estado}, 8'b00100000);
      chk("reset_nfallas", nfallas, 8'd0);
      reset = 1'b0;
      enc = 1'b1;
      ticks(LAT - 1);
      chk("off_before_start", {2'b00, estado}, 8'b00100000);
      tick();
      chk("first_start", {2'b00, estado}, 8'b00000000);
      ticks(T_ARR - 1);
      chk("last_start", {2'b00, estado}, 8'b00000000);
      tick();
      chk("first_run", {2'b00, estado}, 8'b00000001);
      chk("run_nfallas", nfallas, 8'd0);

      // Fault on sens[1], release, acknowledge.
      sens = 3'b010;
      ticks(LAT);
      chk("alarm_set", {2'b00, estado}, 8'b00010100);
      chk("nf_not_yet", nfallas, 8'd0);
      tick();
      chk("nf_one", nfallas, 8'd1);
      sens = 3'b000;
      ticks(LAT);
      chk("alarm_latched", {2'b00, estado}, 8'b00010000);
      ack = 1'b1;
      ticks(LAT);
      chk("ack_clears", {2'b00, estado}, 8'b00000001);
      ack = 1'b0;
      ticks(LAT + 2);

      // Ack during a live fault is discarded.
      sens = 3'b001;
      ticks(LAT);
      chk("fault0", {2'b00, estado}, 8'b00010010);
      ack = 1'b1;
      ticks(LAT + 2);
      chk("ack_ignored", {2'b00, estado}, 8'b00010010);
      ack = 1'b0;
      ticks(LAT + 2);
      sens = 3'b000;
      ticks(LAT);
      chk("still_latched", {2'b00, estado}, 8'b00010000);
      ack = 1'b1;
      ticks(LAT);
      chk("second_ack", {2'b00, estado}, 8'b00000001);
      ack = 1'b0;
      ticks(LAT + 2);
      chk("nf_two", nfallas, 8'd2);

      // Three-cycle glitch on sens[2].
      sens = 3'b100;
      ticks(3);
`ifndef ESTADO_DEBOUNCE_EN
      chk("glitch_seen", {2'b00, estado}, 8'b00011000);
`endif
      sens = 3'b000;
      ticks(LAT + 2);
`ifdef ESTADO_DEBOUNCE_EN
      chk("glitch_filtered", {2'b00, estado}, 8'b00000001);
      enc = 1'b0;
      ticks(3);
      enc = 1'b1;
      ticks(LAT + 2);
      chk("enc_glitch_filtered", {2'b00, estado}, 8'b00000001);
`endif
      ack = 1'b1;
      ticks(LAT + 1);
      ack = 1'b0;
      ticks(LAT + 2);
      chk("after_glitch", {2'b00, estado}, 8'b00000001);
      chk("nf_after_glitch", nfallas, 8'(NF_AFTER_GLITCH));

      // Power drop with alarm latched.
      sens = 3'b001;
      ticks(LAT + 2);
      sens = 3'b000;
      enc = 1'b0;
      ticks(LAT);
      chk("power_drop", {2'b00, estado}, 8'b00100000);
      enc = 1'b1;
      ticks(LAT);
      chk("restart", {2'b00, estado}, 8'b00000000);
      ticks(T_ARR);
      chk("rerun_no_alarm", {2'b00, estado}, 8'b00000001);
      chk("nf_retained", nfallas, 8'(NF_AFTER_GLITCH + 1));

      // Saturation of the event counter.
      for (int n = 0; n < 300; n++) begin
         sens = 3'b001;
         ticks(LAT + 1);
         sens = 3'b000;
         ticks(LAT + 1);
         ack = 1'b1;
         ticks(LAT + 1);
         ack = 1'b0;
         ticks(LAT + 1);
      end
      chk("nf_saturated", nfallas, 8'd255);

      // Reset in the middle of START.
      enc = 1'b0;
      ticks(LAT + 2);
      enc = 1'b1;
      ticks(LAT + 3);
      chk("mid_start", {2'b00, estado}, 8'b00000000);
      reset = 1'b1;
      tick();
      chk("midstart_reset_estado", {2'b00, estado}, 8'b00100000);
      chk("midstart_reset_nf", nfallas, 8'd0);
      reset = 1'b0;

      // Randomized stimulus, checked every cycle against the model.
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(0, 299) == 0) enc = ~enc;
         if ($urandom_range(0, 9) == 0) sens = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 6) == 0) ack = ~ack;
         reset = ($urandom_range(0, 1999) == 0);
         tick();
      end
      reset = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/estado_fsm.md
# estado_fsm

Supervisory state machine that sits directly upstream of the 7-segment display controller and produces its 6-bit one-hot/flag `estado` word. It synchronizes and debounces a power switch, three fault sensors and an operator acknowledge button. It sequences OFF → START → RUN, latches alarms until they are acknowledged, and counts alarm events. `estado` is fully registered and changes only on `clk` edges, so the display sees a glitch-free code.

## Interface
- `DEB`, 16, consecutive stable cycles required before a synchronized input is accepted (debounce enabled; 1 ≤ DEB ≤ 65535)
- `T_ARR`, 1000, duration of START state in cycles (1 ≤ T_ARR ≤ 65535)
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  synchronous, active-high reset
- `enc`  in  1  raw power switch, 1 = on
- `sens`  in  3  raw fault sensors, 1 = fault present
- `ack`  in  1  raw operator acknowledge button
- `estado`  out  6  display code: [5] off, [4] alarm latched, [3:1] live faults sens[2:0], [0] normal
- `nfallas`  out  8  count of alarm-latch set events, saturating

## Operation
- Input path, per bit (`enc`, `sens[2:0]`, `ack`): 2-FF synchronizer, then debouncer.
- Debouncer: holds an accepted value `d`.
  - Counter increments each cycle the synced value ≠ `d`; any cycle with synced value = `d` clears it.
  - `d` takes the synced value on the cycle the counter would reach DEB, then the counter clears.
  - Reset: all `d` = 0, all counters = 0, synchronizers = 0.
- `ack_pulse` = one-cycle rising-edge detect on debounced `ack`.
- Let `f` = debounced `sens`, `on` = debounced `enc`.
- States:
  - OFF: `estado`=6'b100000. Go to START when `on`=1.
  - START: `estado`=6'b000000 (display blank). Lasts exactly T_ARR cycles, then RUN. `f` is ignored and the alarm latch is not set.
  - RUN: `estado` = {1'b0, alm, f[2:0], ~alm & ~|f}.
- Leaving any state: `on`=0 goes to OFF on the next edge from START or RUN. The START counter and `alm` clear; `nfallas` keeps its value.
- Alarm latch `alm`:
  - Set in RUN on any cycle with |f=1.
  - Cleared by `ack_pulse` only if f==0 in that same cycle; otherwise the ack is discarded.
  - A simultaneous new fault and ack leaves `alm`=1.
- `nfallas` increments on each 0→1 transition of `alm` and saturates at 8'd255. Only `reset` clears it.
- Reset values: `estado`=6'b100000, `nfallas`=8'd0, state OFF, `alm`=0.

## Timing
- `estado` and `nfallas` are registered outputs; there is no combinational path from any input.
- Raw input change to `estado` update: DEB+3 rising edges with debounce, counting the sampling edge; 3 edges without.
- START → RUN: first RUN code appears T_ARR edges after the first START code.
- Alarm set: `alm` and `estado[4]` rise on the same edge that `estado[3:1]` first shows the fault. `nfallas` updates on the following edge.
- Ack: `estado[4]` clears 1 edge after the debounced `ack` rises; `estado[0]` rises on the same edge.
- `reset` asserted mid-operation forces reset values on the next edge, overriding all other events.

## Configuration
- `ESTADO_DEBOUNCE_EN` defined: debouncers are present as described; DEB is used.
- `ESTADO_DEBOUNCE_EN` undefined: debouncers are removed and `d` = synchronizer output directly. DEB is ignored, and all other behaviour is unchanged.

## Test plan
All scenarios use DEB=4, T_ARR=8, with the macro defined unless stated.
- Reset then `enc`=1 held: `estado`=100000 for 7 edges, then 000000 for 8 edges, then 000001; `nfallas`=0.
- In RUN, `sens`=3'b010 held: `estado`=010100 after 7 edges and `nfallas`=1 one edge later. Release `sens` → `estado`=010000. Pulse `ack` (≥4 cycles) → `estado`=000001.
- `ack` pressed while `sens[0]`=1: `estado` stays 010010 and `alm` stays set; after `sens` is released, `estado`=010000 until a second ack.
- Glitch of 3 cycles on `sens[2]` or `enc`: no `estado` change. With `ESTADO_DEBOUNCE_EN` undefined, the same glitch shows 011000 after 3 edges.
- Drop `enc` in RUN with `alm`=1: `estado`=100000 after 7 edges; re-enable → START, then 000001 (`alm` cleared); `nfallas` retained.
- 300 set/ack alarm cycles: `nfallas` saturates at 255. `reset` asserted mid-START gives `estado`=100000 and `nfallas`=0 on the next edge.
